// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller:
// opcode values, FSM states, instruction field positions and flag bit indices.
package alu_pkg;

   localparam int ALU_DATA_W = 16;
   localparam int ALU_REG_AW = 3;
   localparam int ALU_OP_W   = 5;

   // ALU opcodes (pass-through encoding) plus the controller-local LDI
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_MUL  = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_NOT  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_XOR  = 5'd7;
   localparam logic [4:0] OP_INC  = 5'd8;
   localparam logic [4:0] OP_CMP  = 5'd9;
   localparam logic [4:0] OP_RR   = 5'd10;
   localparam logic [4:0] OP_RL   = 5'd11;
   localparam logic [4:0] OP_SETB = 5'd12;
   localparam logic [4:0] OP_CLRB = 5'd13;
   localparam logic [4:0] OP_SETF = 5'd14;
   localparam logic [4:0] OP_SWAP = 5'd15;
   localparam logic [4:0] OP_LDI  = 5'd16;

   // Controller FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      WB1   = 2'd3
   } state_t;

   // Instruction field bit positions
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 11;
   localparam int RD_HI  = 10;
   localparam int RD_LO  = 8;
   localparam int RS1_HI = 7;
   localparam int RS1_LO = 5;
   localparam int RS2_HI = 4;
   localparam int RS2_LO = 2;
   localparam int BP_HI  = 4;
   localparam int BP_LO  = 1;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // Architectural flag bit indices
   localparam int FLAG_LT = 0;
   localparam int FLAG_GT = 2;
   localparam int FLAG_EQ = 3;

   // Opcodes below 16 are executed by the ALU
   function automatic logic is_alu_op(input logic [4:0] op);
      return (op[4] == 1'b0);
   endfunction

   // MUL and DIV return a second word that needs an extra writeback cycle
   function automatic logic is_two_result(input logic [4:0] op);
      return ((op == OP_MUL) || (op == OP_DIV));
   endfunction

   // CMP and SETF only update flags
   function automatic logic writes_rd(input logic [4:0] op);
      return !((op == OP_CMP) || (op == OP_SETF));
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two combinational operand read ports, one combinational
// debug read port and one synchronous write port, all cleared by async reset.
// Optional feature macro: ALU_ISSUE_R0_ZERO_EN -- r0 reads as zero and every
// write addressed to r0 is dropped.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int REG_AW = ALU_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int NUM_REGS = 1 << REG_AW;

`ifdef ALU_ISSUE_R0_ZERO_EN
   localparam logic R0_ZERO = 1'b1;
`else
   localparam logic R0_ZERO = 1'b0;
`endif

   logic [DATA_W-1:0] regs_r [NUM_REGS];
   logic              wr_allowed_s;

   assign wr_allowed_s = wr_en && !(R0_ZERO && (wr_addr == {REG_AW{1'b0}}));

   assign rd_data_a = (R0_ZERO && (rd_addr_a == {REG_AW{1'b0}})) ? {DATA_W{1'b0}} : regs_r[rd_addr_a];
   assign rd_data_b = (R0_ZERO && (rd_addr_b == {REG_AW{1'b0}})) ? {DATA_W{1'b0}} : regs_r[rd_addr_b];
   assign dbg_data  = (R0_ZERO && (dbg_addr  == {REG_AW{1'b0}})) ? {DATA_W{1'b0}} : regs_r[dbg_addr];

   // Register storage: cleared on reset, single write per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_allowed_s) begin
         regs_r[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue and writeback controller for the registered 16-bit ALU. Accepts one
// instruction at a time, drives registered operands to the ALU, and writes the
// ALU results back into the register file and the flags register.
// Optional feature macro: ALU_ISSUE_R0_ZERO_EN (hard-wired zero r0, handled
// inside alu_regfile).
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int REG_AW = ALU_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [4:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_operand_1,
   output logic [DATA_W-1:0] alu_operand_2,
   output logic [3:0]        alu_bit_position,
   input  logic [DATA_W-1:0] alu_result_0,
   input  logic [DATA_W-1:0] alu_result_1,
   input  logic [DATA_W-1:0] alu_flag_reg,
   output logic [DATA_W-1:0] flags_q,
   output logic              done,
   output logic              illegal,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            state_r;
   state_t            state_nxt_s;

   // Decoded instruction fields
   logic [4:0]        op_in_s;
   logic [REG_AW-1:0] rd_in_s;
   logic [REG_AW-1:0] rs1_in_s;
   logic [REG_AW-1:0] rs2_in_s;
   logic [3:0]        bp_in_s;
   logic [7:0]        imm_in_s;
   logic              accept_s;
   logic              accept_alu_s;

   // In-flight instruction context
   logic [REG_AW-1:0] rd_r;
   logic [DATA_W-1:0] hold_r;

   // Register file ports
   logic [DATA_W-1:0] rs1_data_s;
   logic [DATA_W-1:0] rs2_data_s;
   logic              wr_en_s;
   logic [REG_AW-1:0] wr_addr_s;
   logic [DATA_W-1:0] wr_data_s;

   // Per-cycle control decisions
   logic              done_nxt_s;
   logic              illegal_nxt_s;
   logic              flags_we_s;
   logic              hold_we_s;

   assign op_in_s  = instr[OPC_HI:OPC_LO];
   assign rd_in_s  = instr[RD_HI:RD_LO];
   assign rs1_in_s = instr[RS1_HI:RS1_LO];
   assign rs2_in_s = instr[RS2_HI:RS2_LO];
   assign bp_in_s  = instr[BP_HI:BP_LO];
   assign imm_in_s = instr[IMM_HI:IMM_LO];

   assign instr_ready  = (state_r == IDLE);
   assign accept_s     = instr_valid && instr_ready;
   assign accept_alu_s = accept_s && is_alu_op(op_in_s);

   alu_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (rs1_in_s),
      .rd_data_a (rs1_data_s),
      .rd_addr_b (rs2_in_s),
      .rd_data_b (rs2_data_s),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .wr_en     (wr_en_s),
      .wr_addr   (wr_addr_s),
      .wr_data   (wr_data_s)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: only ALU ops leave IDLE; MUL/DIV take the extra WB1 step
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_alu_s) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            state_nxt_s = WAIT;
         end
         WAIT: begin
            if (is_two_result(alu_opcode)) begin
               state_nxt_s = WB1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WB1: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM outputs: register-file write port, flag/hold capture and retire pulses
   always_comb begin
      wr_en_s       = 1'b0;
      wr_addr_s     = rd_r;
      wr_data_s     = alu_result_0;
      done_nxt_s    = 1'b0;
      illegal_nxt_s = 1'b0;
      flags_we_s    = 1'b0;
      hold_we_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s && (op_in_s == OP_LDI)) begin
               wr_en_s    = 1'b1;
               wr_addr_s  = rd_in_s;
               wr_data_s  = {{(DATA_W-8){1'b0}}, imm_in_s};
               done_nxt_s = 1'b1;
            end else if (accept_s && !is_alu_op(op_in_s)) begin
               illegal_nxt_s = 1'b1;
            end else begin
               wr_en_s = 1'b0;
            end
         end
         ISSUE: begin
            wr_en_s = 1'b0;
         end
         WAIT: begin
            flags_we_s = 1'b1;
            if (is_two_result(alu_opcode)) begin
               wr_en_s   = 1'b1;
               hold_we_s = 1'b1;
            end else if (writes_rd(alu_opcode)) begin
               wr_en_s    = 1'b1;
               done_nxt_s = 1'b1;
            end else begin
               done_nxt_s = 1'b1;
            end
         end
         WB1: begin
            wr_en_s    = 1'b1;
            wr_addr_s  = rd_r + {{(REG_AW-1){1'b0}}, 1'b1};
            wr_data_s  = hold_r;
            done_nxt_s = 1'b1;
         end
         default: begin
            wr_en_s = 1'b0;
         end
      endcase
   end

   // Registered ALU ports, in-flight context, flags, hold word and pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_opcode       <= 5'd0;
         alu_operand_1    <= {DATA_W{1'b0}};
         alu_operand_2    <= {DATA_W{1'b0}};
         alu_bit_position <= 4'd0;
         rd_r             <= {REG_AW{1'b0}};
         hold_r           <= {DATA_W{1'b0}};
         flags_q          <= {DATA_W{1'b0}};
         done             <= 1'b0;
         illegal          <= 1'b0;
      end else begin
         done    <= done_nxt_s;
         illegal <= illegal_nxt_s;
         if (accept_alu_s) begin
            alu_opcode       <= op_in_s;
            alu_operand_1    <= rs1_data_s;
            alu_operand_2    <= rs2_data_s;
            alu_bit_position <= bp_in_s;
            rd_r             <= rd_in_s;
         end
         if (flags_we_s) begin
            flags_q <= alu_flag_reg;
         end
         if (hold_we_s) begin
            hold_r <= alu_result_1;
         end
      end
   end

endmodule
